pipe_stage_reg: RTL

//  Parametrised inter-stage pipeline register for the MIPS core (ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg_if.sv | 17 +
 rtl/pipe_stage_reg.sv | 114 +++++++++++
 2 files changed

// File: rtl/pipe_stage_reg_if.sv
// Purpose : payload bundle carried between two MIPS pipeline stages
//           (valid bit, control bits, data payload, destination register index).
// Modports: master - drives the bundle (stage output side)
//           slave  - receives the bundle (stage input side)
interface pipe_stage_reg_if #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CTRL_W = 3,
   parameter int unsigned REG_W  = 5
);
   logic              valid;
   logic [CTRL_W-1:0] ctrl;
   logic [DATA_W-1:0] data;
   logic [REG_W-1:0]  writereg;

   modport master (output valid, ctrl, data, writereg);
   modport slave  (input  valid, ctrl, data, writereg);
endinterface

// File: rtl/pipe_stage_reg.sv
// Purpose : inter-stage pipeline register (ID/EX, EX/MEM, MEM/WB) made of DEPTH
//           slices, with hazard-unit stall (hold) and flush (bubble insertion),
//           plus saturating stall/flush event counters.
// Ports   : i_clk       clock, rising edge
//           i_rst       synchronous active-high reset
//           i_stall     hold every slice this cycle
//           i_flush     kill every slice this cycle (valid=0, ctrl=0)
//           i_cntclr    clear both event counters
//           i_e         upstream bundle (valid/ctrl/data/writereg), slave side
//           o_m         downstream bundle from the last slice, master side
//           o_stallcnt  cycles in which a stall took effect (saturating)
//           o_flushcnt  flush cycles (saturating)
module pipe_stage_reg #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CTRL_W = 3,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned DEPTH  = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_stall,
   input  logic                     i_flush,
   input  logic                     i_cntclr,
   pipe_stage_reg_if.slave          i_e,
   pipe_stage_reg_if.master         o_m,
   output logic [CNT_W-1:0]         o_stallcnt,
   output logic [CNT_W-1:0]         o_flushcnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Slice count is limited to what the hazard unit is designed around.
   if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("pipe_stage_reg: DEPTH must be in 1..4");
   end

   // Pipeline slices; index 0 captures the inputs, DEPTH-1 drives the outputs.
   logic [DEPTH-1:0]             r_valid;
   logic [DEPTH-1:0][CTRL_W-1:0] r_ctrl;
   logic [DEPTH-1:0][DATA_W-1:0] r_data;
   logic [DEPTH-1:0][REG_W-1:0]  r_wreg;

   logic [CNT_W-1:0] r_stallcnt;
   logic [CNT_W-1:0] r_flushcnt;
   logic [CNT_W-1:0] w_stallcnt_nxt;
   logic [CNT_W-1:0] w_flushcnt_nxt;
   logic [CTRL_W-1:0] w_ctrl_in;

   // Bubble rule: an invalid slot never carries live control bits.
   assign w_ctrl_in = i_e.valid ? i_e.ctrl : '0;

   // Slice update: reset > flush > stall > shift.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid <= '0;
         r_ctrl  <= '0;
         r_data  <= '0;
         r_wreg  <= '0;
      end else if (i_flush) begin
         // Data and index are left as-is; they are meaningless once valid=0.
         r_valid <= '0;
         r_ctrl  <= '0;
      end else if (!i_stall) begin
         r_valid[0] <= i_e.valid;
         r_ctrl[0]  <= w_ctrl_in;
         r_data[0]  <= i_e.data;
         r_wreg[0]  <= i_e.writereg;
         for (int i = 1; i < int'(DEPTH); i++) begin
            r_valid[i] <= r_valid[i-1];
            r_ctrl[i]  <= r_ctrl[i-1];
            r_data[i]  <= r_data[i-1];
            r_wreg[i]  <= r_wreg[i-1];
         end
      end
   end

   // Event counter next values; clear wins over any increment.
   always_comb begin
      w_stallcnt_nxt = r_stallcnt;
      w_flushcnt_nxt = r_flushcnt;
      if (i_cntclr) begin
         w_stallcnt_nxt = '0;
         w_flushcnt_nxt = '0;
      end else if (i_flush) begin
         if (r_flushcnt != CNT_MAX) begin
            w_flushcnt_nxt = r_flushcnt + CNT_W'(1);
         end
      end else if (i_stall) begin
         if (r_stallcnt != CNT_MAX) begin
            w_stallcnt_nxt = r_stallcnt + CNT_W'(1);
         end
      end
   end

   // Event counter registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stallcnt <= '0;
         r_flushcnt <= '0;
      end else begin
         r_stallcnt <= w_stallcnt_nxt;
         r_flushcnt <= w_flushcnt_nxt;
      end
   end

   assign o_m.valid    = r_valid[DEPTH-1];
   assign o_m.ctrl     = r_ctrl[DEPTH-1];
   assign o_m.data     = r_data[DEPTH-1];
   assign o_m.writereg = r_wreg[DEPTH-1];
   assign o_stallcnt   = r_stallcnt;
   assign o_flushcnt   = r_flushcnt;

endmodule
